// File: rtl/cache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_if
// Bundles the I-cache, D-cache and memory-side signals of cache_mem_arbiter.
//   master : arbiter view (drives mem_* strobes/data, ready pulses, rdata)
//   slave  : environment view (caches and memory model)
// Signals:
//   ic_read/ic_addr/ic_rdata/ic_ready          I-cache refill port
//   dc_read/dc_write/dc_addr/dc_wdata/
//   dc_rdata/dc_ready                          D-cache refill/write-back port
//   mem_read/mem_write/mem_addr/mem_wdata/
//   mem_rdata/mem_ready                        off-chip memory port
// ---------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              ic_read;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_ready;

  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  ic_read, ic_addr,
    input  dc_read, dc_write, dc_addr, dc_wdata,
    input  mem_rdata, mem_ready,
    output ic_rdata, ic_ready,
    output dc_rdata, dc_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output ic_read, ic_addr,
    output dc_read, dc_write, dc_addr, dc_wdata,
    output mem_rdata, mem_ready,
    input  ic_rdata, ic_ready,
    input  dc_rdata, dc_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one off-chip memory port between the I-cache refill path and the
// D-cache refill/write-back path, one line transaction at a time. All
// memory-side and requester-side outputs are registered; each requester
// receives a single-cycle ready pulse when its transaction completes.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    cache_mem_arbiter_if.master (I-cache, D-cache and memory signals)
//
// Build option:
//   ARB_FIXED_DPRIO_EN  defined   -> ties always go to the D-cache
//                       undefined -> ties alternate (round-robin on last grant)
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_mem_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RESP} state_t;

  state_t            r_state;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_ic_rdata;
  logic [DATA_W-1:0] r_dc_rdata;
  logic              r_ic_ready;
  logic              r_dc_ready;
`ifndef ARB_FIXED_DPRIO_EN
  logic              r_last_grant_d;  // 0 = I-cache was granted last, 1 = D-cache
`endif

  logic w_ic_req;
  logic w_dc_req;
  logic w_grant_d;

  assign w_ic_req = bus.ic_read;
  assign w_dc_req = bus.dc_read | bus.dc_write;

`ifdef ARB_FIXED_DPRIO_EN
  assign w_grant_d = w_dc_req;
`else
  // On a tie the side that was not granted last wins; reset leaves last=I,
  // so the first tie goes to D.
  assign w_grant_d = w_dc_req & (~w_ic_req | ~r_last_grant_d);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
      r_ic_ready  <= 1'b0;
      r_dc_ready  <= 1'b0;
`ifndef ARB_FIXED_DPRIO_EN
      r_last_grant_d <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_mem_addr <= bus.dc_addr;
`ifndef ARB_FIXED_DPRIO_EN
            r_last_grant_d <= 1'b1;
`endif
            // A pending write-back is always served before the refill.
            if (bus.dc_write) begin
              r_state     <= D_WR;
              r_mem_write <= 1'b1;
              r_mem_wdata <= bus.dc_wdata;
            end else begin
              r_state    <= D_RD;
              r_mem_read <= 1'b1;
            end
          end else if (w_ic_req) begin
            r_state    <= I_RD;
            r_mem_read <= 1'b1;
            r_mem_addr <= bus.ic_addr;
`ifndef ARB_FIXED_DPRIO_EN
            r_last_grant_d <= 1'b0;
`endif
          end
        end

        I_RD: begin
          if (bus.mem_ready) begin
            r_state    <= RESP;
            r_mem_read <= 1'b0;
            r_ic_rdata <= bus.mem_rdata;
            r_ic_ready <= 1'b1;
          end
        end

        D_RD: begin
          if (bus.mem_ready) begin
            r_state    <= RESP;
            r_mem_read <= 1'b0;
            r_dc_rdata <= bus.mem_rdata;
            r_dc_ready <= 1'b1;
          end
        end

        D_WR: begin
          if (bus.mem_ready) begin
            r_state     <= RESP;
            r_mem_write <= 1'b0;
            r_dc_ready  <= 1'b1;
          end
        end

        // Requests are deliberately not looked at here: a requester dropping
        // its request on this edge must not be granted again.
        RESP: begin
          r_state    <= IDLE;
          r_ic_ready <= 1'b0;
          r_dc_ready <= 1'b0;
        end

        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_ic_ready  <= 1'b0;
          r_dc_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.ic_rdata  = r_ic_rdata;
  assign bus.ic_ready  = r_ic_ready;
  assign bus.dc_rdata  = r_dc_rdata;
  assign bus.dc_ready  = r_dc_ready;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Directed checks (reset values, lone I read, reset during a read) followed
// by randomized I/D traffic. Requester tasks push expected transactions into
// queues; a memory model / grant monitor and a response monitor pop and
// compare against the arbitration rules (round-robin tie-break, write-back
// before refill, fixed latency relations).
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic fail(input string name, input string got, input string want);
    total++;
    bad++;
    $display("FAIL %s: got=%s want=%s", name, got, want);
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dreq_t;

  logic [AW-1:0] i_req_q[$];
  dreq_t         d_req_q[$];
  logic [DW-1:0] i_resp_q[$];
  logic [DW-1:0] d_resp_q[$];
  bit            mon_en = 0;

  // ---------------- memory model + grant checker ----------------
  int            cyc = 0;
  int            last_resp_cyc = -10;
  bit            busy = 0, ready_sent = 0, who_d = 0, cur_rd = 0;
  bit            last_d = 0;           // reference model: D was granted last
  bit            prev_i = 0, prev_d = 0;
  int            lat = 0, cnt = 0;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [DW-1:0] d_hold = '0;          // value dc_rdata should be holding
  logic [DW-1:0] rd;
  dreq_t         ent;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && ready_sent) begin
        chk("resp_strobe_drop", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("ready_route", {bus.ic_ready, bus.dc_ready}, who_d ? 2'b01 : 2'b10);
        busy = 0;
        last_resp_cyc = cyc;
        bus.mem_ready = ($urandom_range(0, 2) == 0);
      end else if (busy || bus.mem_read || bus.mem_write) begin
        if (!busy) begin
          chk("idle_gap_ok", (cyc - last_resp_cyc >= 2), 1'b1);
          if (!prev_i && !prev_d) begin
            fail("spurious_grant", "strobe", "no strobe");
            who_d = bus.mem_write;
          end else begin
`ifdef ARB_FIXED_DPRIO_EN
            who_d = prev_d;
`else
            who_d = prev_d && (!prev_i || !last_d);
`endif
            last_d = who_d;
          end
          cur_addr  = bus.mem_addr;
          cur_wdata = bus.mem_wdata;
          cur_rd    = bus.mem_read;
          if (who_d) begin
            if (d_req_q.size() == 0) fail("d_grant_unexpected", "grant", "none");
            else begin
              ent = d_req_q.pop_front();
              chk("d_op", {bus.mem_read, bus.mem_write}, ent.wr ? 2'b01 : 2'b10);
              chk("d_addr", bus.mem_addr, ent.addr);
              if (ent.wr) chk("d_wdata", bus.mem_wdata, ent.wdata);
            end
          end else begin
            if (i_req_q.size() == 0) fail("i_grant_unexpected", "grant", "none");
            else begin
              chk("i_op", {bus.mem_read, bus.mem_write}, 2'b10);
              chk("i_addr", bus.mem_addr, i_req_q.pop_front());
            end
          end
          busy = 1;
          ready_sent = 0;
          cnt = 0;
          lat = $urandom_range(0, 3);
        end else begin
          chk("strobe_held", {bus.mem_read, bus.mem_write}, cur_rd ? 2'b10 : 2'b01);
          chk("addr_stable", bus.mem_addr, cur_addr);
          if (!cur_rd) chk("wdata_stable", bus.mem_wdata, cur_wdata);
        end
        if (cnt == lat) begin
          rd = {$urandom, $urandom, $urandom, $urandom};
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rd;
          ready_sent = 1;
          if (who_d) begin
            if (cur_rd) d_hold = rd;
            d_resp_q.push_back(d_hold);
          end else begin
            i_resp_q.push_back(rd);
          end
        end else begin
          bus.mem_ready = 1'b0;
          cnt++;
        end
      end else begin
        // mem_ready noise while no transaction is open must be ignored
        bus.mem_ready = ($urandom_range(0, 2) == 0);
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      prev_i = bus.ic_read;
      prev_d = bus.dc_read | bus.dc_write;
      cyc++;
    end
  end

  // ---------------- response monitor ----------------
  bit prev_icr = 0, prev_dcr = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.ic_ready) begin
        if (prev_icr) fail("ic_ready_pulse", "2 cycles", "1 cycle");
        if (i_resp_q.size() == 0) fail("ic_ready_unexpected", "ready=1", "no pending");
        else chk("ic_rdata", bus.ic_rdata, i_resp_q.pop_front());
      end
      if (bus.dc_ready) begin
        if (prev_dcr) fail("dc_ready_pulse", "2 cycles", "1 cycle");
        if (d_resp_q.size() == 0) fail("dc_ready_unexpected", "ready=1", "no pending");
        else chk("dc_rdata", bus.dc_rdata, d_resp_q.pop_front());
      end
      prev_icr = bus.ic_ready;
      prev_dcr = bus.dc_ready;
    end
  end

  // ---------------- requesters (drive at posedge + 1) ----------------
  task automatic wait_ready(input bit is_d, input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (is_d ? bus.dc_ready : bus.ic_ready) break;
    end
    if (k == 200) fail(nm, "no ready", "ready within 200 cycles");
  endtask

  task automatic i_requester(input int n);
    for (int t = 0; t < n; t++) begin
      int            gap;
      logic [AW-1:0] a;
      gap = (t == 0) ? 0 : $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      a = AW'($urandom);
      i_req_q.push_back(a);
      bus.ic_addr = a;
      bus.ic_read = 1'b1;
      wait_ready(1'b0, "ic_timeout");
      bus.ic_read = 1'b0;
      bus.ic_addr = AW'($urandom);
    end
  endtask

  task automatic d_requester(input int n);
    for (int t = 0; t < n; t++) begin
      int    gap;
      int    op;
      dreq_t e;
      gap = (t == 0) ? 0 : $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      op = (t == 0) ? 0 : $urandom_range(0, 2);  // 0 read, 1 write, 2 write+read
      e.addr  = AW'($urandom);
      e.wdata = {$urandom, $urandom, $urandom, $urandom};
      e.wr    = (op != 0);
      d_req_q.push_back(e);
      if (op == 2) begin
        e.wr = 1'b0;
        d_req_q.push_back(e);
      end
      bus.dc_addr  = e.addr;
      bus.dc_wdata = e.wdata;
      bus.dc_write = (op != 0);
      bus.dc_read  = (op != 1);
      wait_ready(1'b1, "dc_timeout");
      if (op == 2) begin
        bus.dc_write = 1'b0;
        wait_ready(1'b1, "dc_timeout2");
      end
      bus.dc_write = 1'b0;
      bus.dc_read  = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_read"},  bus.mem_read, 1'b0);
    chk({tag, "_mem_write"}, bus.mem_write, 1'b0);
    chk({tag, "_mem_addr"},  bus.mem_addr, '0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    chk({tag, "_ic_ready"},  bus.ic_ready, 1'b0);
    chk({tag, "_dc_ready"},  bus.dc_ready, 1'b0);
    chk({tag, "_ic_rdata"},  bus.ic_rdata, '0);
    chk({tag, "_dc_rdata"},  bus.dc_rdata, '0);
  endtask

  // ---------------- main sequence ----------------
  logic [DW-1:0] pat_a5;
  initial begin
    pat_a5        = {16{8'hA5}};
    bus.ic_read   = 1'b0;
    bus.ic_addr   = '0;
    bus.dc_read   = 1'b0;
    bus.dc_write  = 1'b0;
    bus.dc_addr   = '0;
    bus.dc_wdata  = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state, then lone I read with mem_ready in the 2nd strobe cycle
    @(negedge clk);
    chk_reset_outputs("rst");
    bus.ic_addr = AW'(28'h0000010);
    bus.ic_read = 1'b1;
    @(negedge clk);
    chk("lone_i_strobe1", {bus.mem_read, bus.mem_write}, 2'b10);
    chk("lone_i_addr", bus.mem_addr, AW'(28'h0000010));
    @(negedge clk);
    chk("lone_i_strobe2", bus.mem_read, 1'b1);
    chk("lone_i_no_early_ready", bus.ic_ready, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat_a5;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.ic_read   = 1'b0;
    chk("lone_i_strobe_drop", bus.mem_read, 1'b0);
    chk("lone_i_ready", bus.ic_ready, 1'b1);
    chk("lone_i_rdata", bus.ic_rdata, pat_a5);
    chk("lone_i_dc_ready", bus.dc_ready, 1'b0);
    @(negedge clk);
    chk("lone_i_ready_end", bus.ic_ready, 1'b0);
    chk("lone_i_rdata_hold", bus.ic_rdata, pat_a5);

    // reset in the 2nd cycle of an I read
    bus.ic_addr = AW'(28'h0000020);
    bus.ic_read = 1'b1;
    @(negedge clk);
    chk("midrst_strobe", bus.mem_read, 1'b1);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.ic_read = 1'b0;
    @(negedge clk);
    chk("midrst_strobe_drop", bus.mem_read, 1'b0);
    chk("midrst_no_ready", bus.ic_ready, 1'b0);
    chk("midrst_rdata_clr", bus.ic_rdata, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_replay", {bus.mem_read, bus.ic_ready}, 2'b00);
    end

    // randomized traffic; first requests tie right after reset
    @(posedge clk);
    #1;
    mon_en = 1;
    fork
      i_requester(25);
      d_requester(25);
    join
    repeat (10) @(posedge clk);
    chk("i_req_left", i_req_q.size(), 0);
    chk("d_req_left", d_req_q.size(), 0);
    chk("i_resp_left", i_resp_q.size(), 0);
    chk("d_resp_left", d_resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Arbitrates the single off-chip memory port between the I-cache refill path, which feeds instruction fetch, and the D-cache refill/write-back path. It takes one line-sized transaction at a time. The memory-side handshake is registered, and each requester gets a one-cycle ready pulse when its transaction completes. It sits between both caches and the memory model, and its grant order decides how long the fetch stage sees memory_stall.

Parameters:
ADDR_W, 28, line address width (32-bit byte address with 16-byte lines)
DATA_W, 128, line data width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ic_read  in  1  I-cache line read request, held until ic_ready
ic_addr  in  ADDR_W  I-cache line address
ic_rdata  out  DATA_W  line returned to I-cache, valid while ic_ready=1
ic_ready  out  1  one-cycle completion pulse to I-cache
dc_read  in  1  D-cache line read request, held until dc_ready
dc_write  in  1  D-cache write-back request, held until dc_ready
dc_addr  in  ADDR_W  D-cache line address
dc_wdata  in  DATA_W  write-back line
dc_rdata  out  DATA_W  line returned to D-cache, valid while dc_ready=1
dc_ready  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory line address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion

Behaviour:
- Reset: rst_n is a synchronous, active-low reset; clk is the clock. On reset:
  - state=IDLE; last_grant=I
  - all outputs 0: mem_read, mem_write, mem_addr, mem_wdata, ic_ready, dc_ready, ic_rdata, dc_rdata
- States: IDLE, I_RD, D_RD, D_WR, RESP.
- IDLE: samples requests and chooses a grant.
  - Only one requester pending: grant it.
  - Both pending: grant the requester not in last_grant (round-robin). The first tie after reset therefore goes to D.
  - D side with dc_write=1: go to D_WR, even if dc_read=1. With dc_read only: go to D_RD.
  - On the grant edge: latch addr and, for D_WR, wdata into the mem_* registers; update last_grant.
- Memory strobes:
  - I_RD/D_RD: mem_read=1.
  - D_WR: mem_write=1.
  - mem_addr and mem_wdata stay stable for the whole transaction.
  - mem_ready is honoured only in these three states; it is ignored in IDLE and RESP.
- Completion (mem_ready=1 in a busy state): at the next edge go to RESP.
  - Drop mem_read/mem_write.
  - Load mem_rdata into the granted rdata register (read states only).
  - Assert the granted ready.
- RESP: lasts exactly one cycle, with ready=1, then returns to IDLE. Requests are ignored in RESP so that a requester dropping its request at the same edge is not re-granted.
- Latency:
  - request seen in IDLE at cycle 0 → strobe from cycle 1 → mem_ready in cycle k≥1 → ready in cycle k+1 → IDLE in cycle k+2.
  - Minimum 3 cycles per transaction; no back-to-back grants without an IDLE cycle.
- dc_read and dc_write high together: the write-back is served first and dc_ready pulses. The D-cache then drops dc_write and keeps dc_read; the read is arbitrated afresh in the following IDLE.
- Requests dropped before ready (illegal for requesters): the arbiter completes the transaction anyway, and the ready pulse is still emitted.
- rdata registers hold their value after RESP until the next read completion for that requester.
- Reset mid-transaction: state→IDLE and strobes drop at the reset edge. No ready pulse is produced, and the abandoned transaction is never replayed.
- Starvation bound: with both requesters continuously asserting, grants strictly alternate I/D.

Optional Feature:
- Macro: ARB_FIXED_DPRIO_EN.
- Defined: the tie-break is fixed D-before-I, and last_grant is unused. D traffic can starve I.
- Undefined: round-robin tie-break as above.

Test Plan:
- Lone I read: ic_read=1, ic_addr=0x0000010, memory replies with mem_ready in 2nd strobe cycle and mem_rdata=0xA5..A5 → mem_read=1 for 2 cycles with mem_addr=0x0000010; ic_ready=1 for exactly 1 cycle with ic_rdata=0xA5..A5; dc_ready stays 0.
- Tie after reset: ic_read and dc_read both asserted in cycle 0, held until served → D served first, then I. Grant order D,I,D,I when the requests are re-asserted continuously for 4 transactions.
- Write-back then refill: dc_write=1, dc_read=1, dc_addr=0x123, dc_wdata=0xDEAD.. → mem_write first with mem_wdata=0xDEAD..; dc_ready pulse; after the cache drops dc_write, a separate mem_read transaction to 0x123.
- Zero-wait memory: mem_ready tied high → every transaction is exactly 3 cycles; ic_ready/dc_ready never stay high for 2 consecutive cycles.
- Reset mid-read: rst_n=0 in the 2nd cycle of I_RD → mem_read=0 on the next edge; no ic_ready pulse; state IDLE.
- ARB_FIXED_DPRIO_EN defined: both requesters asserted continuously for 3 transactions → all three grants go to D; ic_ready stays 0.
